// File: rtl/sum_acc_pkg.sv
// Shared types and default sizing for the sum accumulator slice.
package sum_acc_pkg;

    // Batch controller states: collecting the first sample, accumulating, presenting the total.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

    localparam int SUM_ACC_IN_W  = 3;
    localparam int SUM_ACC_W     = 8;
    localparam int SUM_ACC_BATCH = 4;

endpackage

// File: rtl/sum_acc_add.sv
// Combinational ACC_W-bit adder; the carry out of the top bit flags a wrap of the total.
module sum_acc_add #(
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);

    // One extra bit captures the carry past the accumulator width.
    always_comb begin
        {carry, sum} = {1'b0, a} + {1'b0, b};
    end

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates a fixed batch of {co, s} samples from the ripple-carry adder and
// presents the batch total with a sticky overflow flag over a valid/ready handshake.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int IN_W  = SUM_ACC_IN_W,
    parameter int ACC_W = SUM_ACC_W,
    parameter int BATCH = SUM_ACC_BATCH,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  s,
    input  logic             co,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    acc_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, out_valid_q;

    logic [ACC_W-1:0] sample_ext;
    logic [ACC_W-1:0] add_sum;
    logic             add_carry;
    logic             accept;
    logic             release_res;
    logic [CNT_W-1:0] count_inc;

    // Zero-extend the {co, s} sample to accumulator width.
    always_comb begin
        sample_ext          = '0;
        sample_ext[IN_W:0]  = {co, s};
    end

    sum_acc_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .a     (acc_q),
        .b     (sample_ext),
        .sum   (add_sum),
        .carry (add_carry)
    );

    assign accept      = in_valid & in_ready_q;
    assign release_res = out_valid_q & out_ready;
    assign count_inc   = count_q + CNT_W'(1);

    // Next-state and datapath update; clear overrides any accept or handshake.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_d   = sample_ext;
                        count_d = CNT_W'(1);
                        state_d = (BATCH == 1) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_d   = add_sum;
                        ovf_d   = ovf_q | add_carry;
                        count_d = count_inc;
                        if (count_inc == CNT_W'(BATCH)) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (release_res) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    // State, total and handshake flags; the flags are registered decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= (state_d != HOLD);
            out_valid_q <= (state_d == HOLD);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign acc       = acc_q;
    assign count     = count_q;
    assign ovf       = ovf_q;

endmodule
